// File: rtl/mnist_nn_button_pkg.sv
// Shared definitions for the push-button controller.
// Holds the Avalon word addresses of the four registers, the press counter
// width and saturation value, and a popcount helper.
package mnist_nn_button_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE     = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  // Number of set bits in a 32-bit vector (0..32).
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mnist_nn_button_debounce.sv
// Single-line button conditioner.
// Ports:
//   clk, reset_n : clock and synchronous active-low reset
//   pin          : raw asynchronous button pin
//   stable       : debounced pressed level (1 = pressed)
//   rise         : one-cycle pulse, high in the cycle whose clk edge
//                  moves stable from 0 to 1
module mnist_nn_button_debounce
  import mnist_nn_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level of a released button.
  localparam logic IDLE = ACTIVE_LOW;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level;
  logic             accept;

  // Inversion sits after the synchronizer so the synchronizer only ever sees
  // the raw pin.
  assign level  = sync2_reg ^ IDLE;
  assign accept = (level != stable_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Synchronizers restart at the released pin level so that leaving reset
      // never looks like a press; a button held through reset therefore
      // has to re-qualify through the full debounce window.
      sync1_reg  <= IDLE;
      sync2_reg  <= IDLE;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      sync1_reg <= pin;
      sync2_reg <= sync1_reg;
      if (level == stable_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        stable_reg <= level;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable = stable_reg;
  // Combinational so the register file can capture the press on the same
  // edge that stable changes.
  assign rise   = accept && level;

endmodule

// File: rtl/mnist_nn_button_ctrl.sv
// Avalon-MM slave for the board push-buttons that step and trigger MNIST
// inference runs.
// Ports:
//   clk, reset_n        : clock and synchronous active-low reset
//   address, chipselect,
//   write_n, writedata  : Avalon-MM slave write/select inputs
//   readdata            : combinational read data (zero latency)
//   in_port             : raw button pins
//   irq                 : level interrupt, |(edge_capture & irq_mask), registered
//   pressed             : debounced pressed state
// Registers: 0 DATA (RO), 1 IRQ_MASK (RW), 2 EDGE_CAPTURE (W1C),
//            3 PRESS_COUNT (RO, any write clears, saturating).
module mnist_nn_button_ctrl
  import mnist_nn_button_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [WIDTH-1:0] pressed
);

  generate
    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
      $error("mnist_nn_button_ctrl: WIDTH must be 1..32 and DEBOUNCE_CYCLES >= 2");
    end
  endgenerate

  logic [WIDTH-1:0]   stable;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   irq_mask_reg;
  logic [WIDTH-1:0]   edge_reg;
  logic [WIDTH-1:0]   edge_next;
  logic [WIDTH-1:0]   edge_clear;
  logic [COUNT_W-1:0] count_reg;
  logic [COUNT_W-1:0] count_next;
  logic [COUNT_W:0]   count_sum;
  logic [5:0]         n_press;
  logic               irq_reg;
  logic               wr_en;
  logic [WIDTH-1:0]   wdata;
  logic               unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_line
      mnist_nn_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (in_port[gi]),
        .stable (stable[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // A press arriving on a bit being cleared wins: clear first, then set.
  assign edge_clear = (wr_en && address == ADDR_EDGE) ? wdata : '0;
  assign edge_next  = (edge_reg & ~edge_clear) | rise;

  assign n_press   = popcount32(32'(rise));
  // One extra bit catches overflow so the count clamps instead of wrapping.
  assign count_sum = {1'b0, count_reg} + (COUNT_W + 1)'(n_press);

  always_comb begin
    count_next = count_sum[COUNT_W] ? COUNT_MAX : count_sum[COUNT_W-1:0];
    // A clearing write still keeps the presses of its own cycle.
    if (wr_en && address == ADDR_COUNT) begin
      count_next = COUNT_W'(n_press);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask_reg <= '0;
      edge_reg     <= '0;
      count_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQ_MASK) begin
        irq_mask_reg <= wdata;
      end
      edge_reg  <= edge_next;
      count_reg <= count_next;
      irq_reg   <= |(edge_reg & irq_mask_reg);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(stable);
      ADDR_IRQ_MASK: readdata = 32'(irq_mask_reg);
      ADDR_EDGE:     readdata = 32'(edge_reg);
      ADDR_COUNT:    readdata = 32'(count_reg);
      default:       readdata = '0;
    endcase
  end

  assign irq     = irq_reg;
  assign pressed = stable;

endmodule

// File: tb/tb_mnist_nn_button_ctrl.sv
// Self-checking bench for mnist_nn_button_ctrl (WIDTH=8, DEBOUNCE_CYCLES=4,
// ACTIVE_LOW=1). Stimulus queues expected values; a monitor on the falling
// clock edge pops and compares them against the DUT outputs.
module tb_mnist_nn_button_ctrl;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   address = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic [W-1:0] in_port = '1;
  logic         irq;
  logic [W-1:0] pressed;

  always #5 clk = ~clk;

  mnist_nn_button_ctrl #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq),
    .pressed   (pressed)
  );

  // ---------------- reference model ----------------
  // A button's debounced state follows the pressed level once that level has
  // been seen on DC consecutive pin samples, taken two edges before the
  // current edge (synchronizer delay). Registers follow the register map.
  logic [W-1:0] hist [0:DC+1];
  logic [W-1:0] m_stable = '0;
  logic [W-1:0] m_edge = '0;
  logic [W-1:0] m_mask = '0;
  int           m_count = 0;
  logic         m_irq = 1'b0;

  task automatic model_step();
    logic [W-1:0] all1, all0, rises, falls;
    logic irq_new, wr;
    int pc;
    if (!reset_n) begin
      for (int k = 0; k <= DC + 1; k++) hist[k] = '0;
      m_stable = '0; m_edge = '0; m_mask = '0; m_count = 0; m_irq = 1'b0;
    end else begin
      for (int k = DC + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ~in_port;
      all1 = '1; all0 = '1;
      for (int k = 2; k <= DC + 1; k++) begin
        all1 = all1 & hist[k];
        all0 = all0 & ~hist[k];
      end
      rises = all1 & ~m_stable;
      falls = all0 & m_stable;
      irq_new = |(m_edge & m_mask);
      wr = chipselect && !write_n;
      if (wr && address == 2'd1) m_mask = writedata[W-1:0];
      if (wr && address == 2'd2) m_edge = m_edge & ~writedata[W-1:0];
      m_edge = m_edge | rises;
      pc = $countones(rises);
      if (wr && address == 2'd3) m_count = pc;
      else m_count = (m_count + pc > 65535) ? 65535 : m_count + pc;
      m_stable = (m_stable | rises) & ~falls;
      m_irq = irq_new;
    end
  endtask

  initial begin
    for (int k = 0; k <= DC + 1; k++) hist[k] = '0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_edge);
      default: return 32'(m_count);
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    int          kind;   // 0 readdata, 1 irq, 2 pressed
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  logic [31:0] act;
  int          n_checks = 0;
  int          n_fail = 0;

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        case (cur.kind)
          0:       act = readdata;
          1:       act = 32'(irq);
          default: act = 32'(pressed);
        endcase
        n_checks++;
        if (act !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Read with a constant expectation; consumes one clock edge.
  task automatic rd_exp(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    push(0, exp, name);
    tick(1);
    chipselect = 1'b0;
  endtask

  // Read checked against the model, plus irq and pressed; one clock edge.
  task automatic rd_model(input logic [1:0] a, input string name);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    push(0, model_read(a), name);
    push(1, 32'(m_irq), "irq");
    push(2, 32'(m_stable), "pressed");
    tick(1);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drain;
    // Reset / idle
    in_port = '1; reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    push(1, 32'h0, "reset_irq");
    push(2, 32'h0, "reset_pressed");
    rd_exp(2'd0, 32'h0, "reset_data");
    rd_exp(2'd1, 32'h0, "reset_mask");
    rd_exp(2'd2, 32'h0, "reset_edge");
    rd_exp(2'd3, 32'h0, "reset_count");

    // Glitch shorter than the debounce window
    in_port[0] = 1'b0; tick(3); in_port[0] = 1'b1; tick(8);
    rd_exp(2'd0, 32'h0, "glitch_data");
    rd_exp(2'd2, 32'h0, "glitch_edge");

    // Qualified press: DATA flips on the 6th edge after the pin falls
    in_port[0] = 1'b0; tick(5);
    rd_exp(2'd0, 32'h0, "data_edge5");
    rd_exp(2'd0, 32'h1, "data_edge6");
    tick(3); in_port[0] = 1'b1;
    rd_exp(2'd2, 32'h1, "press_edge");
    rd_exp(2'd3, 32'h1, "press_count");
    tick(10);

    // IRQ path
    wr(2'd2, 32'hFF);
    wr(2'd1, 32'h1);
    push(1, 32'h0, "irq_idle");
    rd_exp(2'd1, 32'h1, "mask_rb");
    in_port[0] = 1'b0; tick(8);
    push(1, 32'h1, "irq_on_press");
    rd_exp(2'd2, 32'h1, "irq_edge");
    in_port[0] = 1'b1; tick(10);
    wr(2'd2, 32'h1);
    push(1, 32'h1, "irq_same_cycle");
    tick(1);
    push(1, 32'h0, "irq_cleared");
    rd_exp(2'd2, 32'h0, "edge_cleared");
    in_port[1] = 1'b0; tick(8); in_port[1] = 1'b1;
    push(1, 32'h0, "irq_masked");
    rd_exp(2'd2, 32'h2, "edge_bit1");
    tick(10);

    // Collision: W1C of bit 2 on the edge bit 2 is captured
    in_port[2] = 1'b0; tick(5);
    wr(2'd2, 32'h4);
    rd_exp(2'd2, 32'h6, "edge_collision");
    in_port[2] = 1'b1; tick(10);
    // Collision: COUNT write on the edge of two presses
    in_port[0] = 1'b0; in_port[3] = 1'b0; tick(5);
    wr(2'd3, 32'h0);
    rd_exp(2'd3, 32'h2, "count_collision");
    in_port[0] = 1'b1; in_port[3] = 1'b1; tick(10);

    // Saturation via backdoor preload
    force dut.count_reg = 16'hFFFE;
    m_count = 32'hFFFE;
    @(negedge clk);
    release dut.count_reg;
    tick(1);
    rd_exp(2'd3, 32'hFFFE, "count_preload");
    in_port[4] = 1'b0; in_port[5] = 1'b0; tick(8);
    in_port[4] = 1'b1; in_port[5] = 1'b1;
    rd_exp(2'd3, 32'hFFFF, "count_saturate");
    tick(10);
    in_port[7] = 1'b0; tick(8); in_port[7] = 1'b1;
    rd_exp(2'd3, 32'hFFFF, "count_hold_max");
    tick(10);

    // Reset mid-debounce with a held button
    wr(2'd2, 32'hFF);
    in_port[6] = 1'b0; tick(8); in_port[6] = 1'b1; tick(10);
    rd_exp(2'd2, 32'h40, "edge_bit6");
    in_port[6] = 1'b0; tick(4);
    reset_n = 1'b0; tick(3); reset_n = 1'b1;
    push(1, 32'h0, "rst2_irq");
    push(2, 32'h0, "rst2_pressed");
    rd_exp(2'd0, 32'h0, "rst2_data");
    rd_exp(2'd1, 32'h0, "rst2_mask");
    rd_exp(2'd2, 32'h0, "rst2_edge");
    rd_exp(2'd3, 32'h0, "rst2_count");
    rd_exp(2'd0, 32'h0, "rst2_data_e5");
    rd_exp(2'd0, 32'h0, "rst2_data_e6pre");
    rd_exp(2'd0, 32'h40, "rst2_data_q");
    rd_exp(2'd2, 32'h40, "rst2_edge_q");
    in_port[6] = 1'b1; tick(10);

    // Randomized traffic against the model
    wr(2'd1, 32'($urandom_range(0, 255)));
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
      end
      case ($urandom_range(0, 7))
        0, 1, 2, 3, 4, 5: rd_model(2'($urandom_range(0, 3)), "rand_read");
        6:               wr(2'($urandom_range(0, 3)), $urandom);
        default:         tick(1);
      endcase
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      tick(1);
      drain++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
